// File: rtl/spike_evt_pkg.sv
// Shared types for the spike event aggregator: FSM states, event payload, vote popcount.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Optional feature: SPIKE_EVT_MASK_EN adds the 4-bit detector mask {neo,ado,aso,ed} to the payload.
package spike_evt_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_REFRACT
   } evt_state_t;

   // Payload carried next to the timestamp in every FIFO word.
   typedef struct packed {
      logic [2:0] votes;
`ifdef SPIKE_EVT_MASK_EN
      logic [3:0] mask;
`endif
   } evt_info_t;

   localparam int EVT_INFO_W = $bits(evt_info_t);

   function automatic logic [2:0] popcount4(input logic [3:0] f);
      return {2'b00, f[3]} + {2'b00, f[2]} + {2'b00, f[1]} + {2'b00, f[0]};
   endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level.
// Latency: a write is visible at rd_dat the cycle after it is written; read data is combinational from the head.
// Backpressure: writes are refused when full unless a read retires in the same cycle; reads while empty are ignored.
// Ports: clk, rst (async active-low), wr_en/wr_dat, rd_en/rd_dat (zero when empty), full, empty, level.
module spike_evt_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             rd_fire;
   logic             wr_fire;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (level == (AW+1)'(DEPTH));
   assign rd_fire = rd_en & ~empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_fire = wr_en & (~full | rd_fire);
   assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero whenever empty.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

endmodule

// File: rtl/spike_event_aggregator.sv
// Fuses four detector flags by vote count, applies a refractory lockout, timestamps and buffers events.
// Latency: a hit on cycle N into an empty buffer shows evt_valid on cycle N+1 (first-word-fall-through).
// Backpressure: evt_valid/evt_ready stream; head held while stalled; events arriving at a full buffer are dropped and counted.
// Ports: clk, rst (async active-low), sample_en, spike_neo/ado/aso/ed in; evt_valid, evt_ready(in), evt_ts,
//        evt_votes, evt_mask (only with SPIKE_EVT_MASK_EN), fifo_level, drop_cnt (saturating) out.
module spike_event_aggregator
   import spike_evt_pkg::*;
#(
   parameter int TS_W        = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int VOTE_MIN    = 2,
   parameter int REFRACT_SMP = 30,
   parameter int DROP_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample_en,
   input  logic                          spike_neo,
   input  logic                          spike_ado,
   input  logic                          spike_aso,
   input  logic                          spike_ed,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [TS_W-1:0]               evt_ts,
   output logic [2:0]                    evt_votes,
`ifdef SPIKE_EVT_MASK_EN
   output logic [3:0]                    evt_mask,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [DROP_W-1:0]             drop_cnt
);

   localparam int RC_W = (REFRACT_SMP > 1) ? $clog2(REFRACT_SMP) : 1;
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT_SMP - 1);

   typedef struct packed {
      logic [TS_W-1:0] ts;
      evt_info_t       info;
   } evt_word_t;

   evt_state_t      state, state_nxt;
   logic [RC_W-1:0] rcnt, rcnt_nxt;
   logic [TS_W-1:0] ts;
   logic [3:0]      flags;
   logic [2:0]      votes;
   logic            hit;
   logic            push;
   logic            pop;
   logic            drop;
   logic            fifo_full;
   logic            fifo_empty;
   evt_word_t       wr_word;
   evt_word_t       rd_word;

   assign flags = {spike_neo, spike_ado, spike_aso, spike_ed};
   assign votes = popcount4(flags);
   assign hit   = sample_en & (votes >= 3'(VOTE_MIN));

   // Lockout counts samples, not clock cycles: without sample_en nothing advances.
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      push      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (hit) begin
               push      = 1'b1;
               rcnt_nxt  = RC_LOAD;
               state_nxt = ST_REFRACT;
            end
         end
         ST_REFRACT: begin
            if (sample_en) begin
               if (rcnt == '0) state_nxt = ST_IDLE;
               else            rcnt_nxt  = rcnt - RC_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         rcnt  <= '0;
         ts    <= '0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
         if (sample_en) ts <= ts + TS_W'(1);
      end
   end

   // The event carries the timestamp of its own sample (pre-increment value).
   always_comb begin
      wr_word            = '0;
      wr_word.ts         = ts;
      wr_word.info.votes = votes;
`ifdef SPIKE_EVT_MASK_EN
      wr_word.info.mask  = flags;
`endif
   end

   spike_evt_fifo #(
      .WIDTH ($bits(evt_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (push),
      .wr_dat (wr_word),
      .rd_en  (evt_ready),
      .rd_dat (rd_word),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   assign pop  = evt_ready & ~fifo_empty;
   assign drop = push & fifo_full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

   assign evt_valid = ~fifo_empty;
   assign evt_ts    = rd_word.ts;
   assign evt_votes = rd_word.info.votes;
`ifdef SPIKE_EVT_MASK_EN
   assign evt_mask  = rd_word.info.mask;
`endif

endmodule

// File: tb/tb_spike_event_aggregator.sv
// Self-checking bench for spike_event_aggregator: queue-based reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: evt_ready driven both held-low and randomly toggled.
module tb_spike_event_aggregator;

   localparam int TS_W  = 8;
   localparam int DEPTH = 16;
   localparam int VMIN  = 2;
   localparam int RSMP  = 30;
   localparam int DW    = 3;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sample_en = 1'b0;
   logic neo = 1'b0, ado = 1'b0, aso = 1'b0, ed = 1'b0;
   logic evt_ready = 1'b0;
   logic            evt_valid;
   logic [TS_W-1:0] evt_ts;
   logic [2:0]      evt_votes;
   logic [LW-1:0]   fifo_level;
   logic [DW-1:0]   drop_cnt;
`ifdef SPIKE_EVT_MASK_EN
   logic [3:0]      evt_mask;
`endif

   always #5 clk = ~clk;

   spike_event_aggregator #(
      .TS_W        (TS_W),
      .FIFO_DEPTH  (DEPTH),
      .VOTE_MIN    (VMIN),
      .REFRACT_SMP (RSMP),
      .DROP_W      (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_en  (sample_en),
      .spike_neo  (neo),
      .spike_ado  (ado),
      .spike_aso  (aso),
      .spike_ed   (ed),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_ts     (evt_ts),
      .evt_votes  (evt_votes),
`ifdef SPIKE_EVT_MASK_EN
      .evt_mask   (evt_mask),
`endif
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int ts;
      int votes;
      int mask;
   } ev_t;

   ev_t mq[$];
   int  m_ts, m_lock, m_drop;
   int  m_evts = 0;
   int  mf, mv;
   bit  mfull, mpop;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // m_lock = number of upcoming samples still locked out after an accepted event.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_ts   = 0;
         m_lock = 0;
         m_drop = 0;
      end else begin
         mfull = (mq.size() == DEPTH);
         mpop  = evt_ready && (mq.size() > 0);
         if (mpop) void'(mq.pop_front());
         if (sample_en) begin
            mf = {neo, ado, aso, ed};
            mv = $countones(mf);
            if (m_lock == 0 && mv >= VMIN) begin
               m_evts++;
               if (!mfull || mpop) mq.push_back('{m_ts, mv, mf});
               else if (m_drop < (1 << DW) - 1) m_drop++;
               m_lock = RSMP;
            end else if (m_lock > 0) begin
               m_lock--;
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
         end
      end
   end

   // Single compare process: every cycle, DUT outputs must equal the model view.
   always @(negedge clk) begin
      chk("cmp_valid", evt_valid, mq.size() > 0);
      chk("cmp_level", fifo_level, mq.size());
      chk("cmp_drop", drop_cnt, m_drop);
      chk("cmp_ts", evt_ts, (mq.size() > 0) ? mq[0].ts : 0);
      chk("cmp_votes", evt_votes, (mq.size() > 0) ? mq[0].votes : 0);
`ifdef SPIKE_EVT_MASK_EN
      chk("cmp_mask", evt_mask, (mq.size() > 0) ? mq[0].mask : 0);
`endif
   end

   // ---------------- stimulus ----------------
   task automatic smp(input bit en, input bit [3:0] f, input bit rdy);
      sample_en = en;
      {neo, ado, aso, ed} = f;
      evt_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Asserts reset mid-cycle (async), checks the cleared state, then releases.
   task automatic do_reset();
      #3;
      rst = 1'b0;
      #1;
      chk("rst_valid", evt_valid, 0);
      chk("rst_ts", evt_ts, 0);
      chk("rst_votes", evt_votes, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_drop", drop_cnt, 0);
`ifdef SPIKE_EVT_MASK_EN
      chk("rst_mask", evt_mask, 0);
`endif
      sample_en = 1'b0;
      {neo, ado, aso, ed} = 4'b0000;
      evt_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One hit followed by a full lockout's worth of quiet samples.
   task automatic spaced_hit();
      smp(1'b1, 4'b1111, 1'b0);
      repeat (RSMP) smp(1'b1, 4'b0000, 1'b0);
   endtask

   int  start_evts;
   int  cyc;
   bit  rdy;
   int  nsmp;

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Vote threshold: a single flag is not a spike, two flags are.
      do_reset();
      repeat (5) smp(1'b1, 4'b0000, 1'b0);
      smp(1'b1, 4'b1000, 1'b0);
      chk("vote_one_flag_level", fifo_level, 0);
      smp(1'b1, 4'b1100, 1'b0);
      chk("vote_valid", evt_valid, 1);
      chk("vote_ts", evt_ts, 6);
      chk("vote_votes", evt_votes, 2);
      chk("vote_level", fifo_level, 1);
`ifdef SPIKE_EVT_MASK_EN
      chk("vote_mask", evt_mask, 4'b1100);
`endif

      // Reset mid-operation with three events queued; ts restarts at 0.
      do_reset();
      repeat (3) spaced_hit();
      chk("mid_level3", fifo_level, 3);
      do_reset();
      smp(1'b1, 4'b1111, 1'b0);
      chk("restart_valid", evt_valid, 1);
      chk("restart_ts", evt_ts, 0);

      // Refractory: continuous hits from ts=10 lock out the next 30 samples.
      do_reset();
      repeat (10) smp(1'b1, 4'b0000, 1'b0);
      repeat (36) smp(1'b1, 4'b1111, 1'b0);
      chk("refr_level", fifo_level, 2);
      chk("refr_drop", drop_cnt, 0);
      chk("refr_first_ts", evt_ts, 10);
      chk("refr_votes", evt_votes, 4);
      smp(1'b0, 4'b1111, 1'b1);
      chk("refr_second_ts", evt_ts, 41);

      // Overflow: 20 events into a 16-deep buffer, then saturate the 3-bit drop counter.
      do_reset();
      repeat (20) spaced_hit();
      chk("ovf_level", fifo_level, 16);
      chk("ovf_drop", drop_cnt, 4);
      chk("ovf_head_ts", evt_ts, 0);
      repeat (5) spaced_hit();
      chk("ovf_drop_sat", drop_cnt, 7);
      smp(1'b0, 4'b0000, 1'b1);
      chk("ovf_next_ts", evt_ts, 31);
      chk("ovf_level_after_pop", fifo_level, 15);

      // Timestamp wrap with sample_en gaps: 257 quiet samples, then a hit at ts 257 mod 256.
      do_reset();
      nsmp = 0;
      while (nsmp < 257) begin
         if ($urandom_range(0, 2) == 0) begin
            smp(1'b0, 4'b1111, 1'b0);
         end else begin
            smp(1'b1, 4'b0000, 1'b0);
            nsmp++;
         end
      end
      smp(1'b0, 4'b1111, 1'b0);
      chk("wrap_gap_no_event", fifo_level, 0);
      smp(1'b1, 4'b0111, 1'b0);
      chk("wrap_ts", evt_ts, 1);
      chk("wrap_votes", evt_votes, 3);

      // Random flags, sample gaps and bursty backpressure; the compare process tracks every cycle.
      do_reset();
      start_evts = m_evts;
      cyc = 0;
      rdy = 1'b1;
      while ((m_evts - start_evts) < 100 && cyc < 20000) begin
         if ($urandom_range(0, 3) == 0) rdy = ~rdy;
         smp($urandom_range(0, 3) != 0, 4'($urandom), rdy);
         cyc++;
      end
      chk("rand_evt_count", (m_evts - start_evts) >= 100, 1);
      repeat (40) smp(1'b0, 4'b0000, 1'b1);
      chk("rand_drained", fifo_level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
